fir_mc_serial_core: RTL and testbench

//  Parametrised successor of the fixed 20-tap FIR: multi-channel, time-multiplexed, serial-MAC FIR core.
//  - One signed multiplier, shared across all channels.
//  - Each channel has its own delay line. All channels share one runtime-loadable coefficient bank.
//  - Sits between the input FIFO and the AHB result path.
//  - Uses valid/ready handshakes on both the sample side and the result side.

---
 rtl/fir_mc_serial_core.sv | 125 ++++++++++++
 tb/tb_fir_mc_serial_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mc_serial_core.sv
// Multi-channel FIR: per-channel delay lines, one shared coefficient bank, one signed multiplier, TAPS-cycle serial MAC.
// Optional FIR_SAT_EN: output rounded half-up to Q1.(BIT_PREC-1), saturated to BIT_PREC range and sign-extended.
module fir_mc_serial_core #(
  parameter int BIT_PREC = 8,
  parameter int TAPS     = 20,
  parameter int CHANNELS = 2,
  localparam int OUT_SIZE = 2*BIT_PREC+$clog2(TAPS),
  localparam int CH_W     = (CHANNELS>1) ? $clog2(CHANNELS) : 1,
  localparam int A_W      = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BIT_PREC-1:0] in_data,
  input  logic [CH_W-1:0]            in_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_SIZE-1:0] out_data,
  output logic [CH_W-1:0]            out_ch,
  input  logic                       coef_we,
  input  logic [A_W-1:0]             coef_addr,
  input  logic signed [BIT_PREC-1:0] coef_data,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [BIT_PREC-1:0] coef  [TAPS];
  logic signed [BIT_PREC-1:0] dline [CHANNELS][TAPS];
  logic [A_W-1:0]             k;
  logic [CH_W-1:0]            ch;
  logic signed [OUT_SIZE-1:0] acc;
  logic signed [2*BIT_PREC-1:0] prod;
  logic signed [OUT_SIZE-1:0] prod_ext, sum, result;
  logic accept, ch_ok, coef_ok, last_tap;

  assign in_ready  = (state == IDLE) && !coef_we && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign last_tap  = (k == A_W'(TAPS-1));

  // Range checks collapse to constant-true when the index width exactly covers the range.
  if (CHANNELS == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (in_ch < CH_W'(CHANNELS));
  end

  if (TAPS == (1 << A_W)) begin : g_a_full
    assign coef_ok = 1'b1;
  end else begin : g_a_part
    assign coef_ok = (coef_addr < A_W'(TAPS));
  end

  assign prod     = coef[k] * dline[ch][k];
  assign prod_ext = {{(OUT_SIZE-2*BIT_PREC){prod[2*BIT_PREC-1]}}, prod};
  assign sum      = acc + prod_ext;

`ifdef FIR_SAT_EN
  localparam logic signed [OUT_SIZE-1:0] HALF    = OUT_SIZE'(2**(BIT_PREC-2));
  localparam logic signed [OUT_SIZE-1:0] SAT_MAX = OUT_SIZE'(2**(BIT_PREC-1)-1);
  localparam logic signed [OUT_SIZE-1:0] SAT_MIN = OUT_SIZE'(-(2**(BIT_PREC-1)));
  logic signed [OUT_SIZE-1:0] rnd;

  always_comb begin
    rnd    = (sum + HALF) >>> (BIT_PREC-1);
    result = rnd;
    if (rnd > SAT_MAX)      result = SAT_MAX;
    else if (rnd < SAT_MIN) result = SAT_MIN;
  end
`else
  assign result = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && ch_ok) state_nxt = MAC;
      MAC:     if (last_tap)        state_nxt = OUT;
      OUT:     if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < TAPS; i++) dline[c][i] <= '0;
      k        <= '0;
      ch       <= '0;
      acc      <= '0;
      out_data <= '0;
      out_ch   <= '0;
    end else begin
      if ((state == IDLE) && coef_we && coef_ok) coef[coef_addr] <= coef_data;
      // Out-of-range channels are consumed here without touching any delay line.
      if (accept && ch_ok) begin
        for (int i = TAPS-1; i > 0; i--) dline[in_ch][i] <= dline[in_ch][i-1];
        dline[in_ch][0] <= in_data;
        ch  <= in_ch;
        acc <= '0;
        k   <= '0;
      end
      if (state == MAC) begin
        acc <= sum;
        k   <= last_tap ? '0 : k + A_W'(1);
        if (last_tap) begin
          out_data <= result;
          out_ch   <= ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mc_serial_core.sv
// Directed bench for fir_mc_serial_core: vector table for impulse/isolation plus hand-written corner sequences.
module tb_fir_mc_serial_core;
  localparam int BIT_PREC = 8;
  localparam int TAPS     = 20;
  localparam int CHANNELS = 2;
  localparam int OUT_SIZE = 2*BIT_PREC+$clog2(TAPS);
  localparam int CH_W     = 1;
  localparam int A_W      = 5;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, coef_we, busy;
  logic signed [BIT_PREC-1:0] in_data, coef_data;
  logic [CH_W-1:0]            in_ch, out_ch;
  logic signed [OUT_SIZE-1:0] out_data;
  logic [A_W-1:0]             coef_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct { int ch; int data; int exp; } vec_t;
  vec_t vt [23];

  always #5 clk = ~clk;

  fir_mc_serial_core #(.BIT_PREC(BIT_PREC), .TAPS(TAPS), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_f(input int acc);
`ifdef FIR_SAT_EN
    int r;
    r = (acc + (1 << (BIT_PREC-2))) >>> (BIT_PREC-1);
    if (r > (1 << (BIT_PREC-1)) - 1) r = (1 << (BIT_PREC-1)) - 1;
    if (r < -(1 << (BIT_PREC-1)))    r = -(1 << (BIT_PREC-1));
    return r;
`else
    return acc;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = A_W'(a);
    coef_data = BIT_PREC'(d);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic accept(input int ch, input int d);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) check("in_ready_wait", 0, 1);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = BIT_PREC'(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin step(); lat++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run(input int ch, input int d, input int e, input string name, input bit chk);
    int lat;
    accept(ch, d);
    wait_out(lat);
    if (chk) begin
      check({name, "_lat"},  lat, TAPS);
      check({name, "_data"}, int'(out_data), exp_f(e));
      check({name, "_ch"},   int'(out_ch), ch);
    end
    release_out();
  endtask

  initial begin
    int lat;
    bit stable;

    vt[0] = '{0, 1, 1};
    vt[1] = '{1, 5, 5};
    for (int i = 1; i <= 20; i++) vt[i+1] = '{0, 0, (i < 20) ? i + 1 : 0};
    vt[22] = '{1, 0, 10};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0;
    out_ready = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    step(); step();
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data),  0);
    check("rst_out_ch",    int'(out_ch),    0);
    check("rst_busy",      int'(busy),      0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Impulse on ch0 with ch1 interleaved.
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    for (int i = 0; i < 23; i++)
      run(vt[i].ch, vt[i].data, vt[i].exp, $sformatf("vec%0d", i), 1'b1);

    // Extremes: all -128.
    for (int i = 0; i < TAPS; i++) write_coef(i, -128);
    for (int i = 0; i < TAPS; i++)
      run(0, -128, (i + 1) * 16384, $sformatf("ext%0d", i), 1'b1);

    // Backpressure: ch1 history 5,0,1 -> -128*(1+5).
    accept(1, 1);
    wait_out(lat);
    check("bp_lat",  lat, TAPS);
    check("bp_data", int'(out_data), exp_f(-768));
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (int'(out_data) != exp_f(-768) || out_ch != 1'b1 || in_ready || !out_valid) stable = 1'b0;
    end
    check("bp_stable", int'(stable), 1);
    release_out();
    check("bp_in_ready_after", int'(in_ready), 1);

    // Coefficient rules.
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    for (int i = 0; i < TAPS; i++) run(0, 0, 0, "flush", 1'b0);
    accept(0, 1);
    step(); step();
    coef_we = 1'b1; coef_addr = A_W'(3); coef_data = 8'sd9;
    #1;
    check("mac_busy", int'(busy), 1);
    step();
    coef_we = 1'b0;
    wait_out(lat);
    check("cw_imp_data", int'(out_data), exp_f(1));
    release_out();
    run(0, 0, 2, "cw_k1", 1'b1);
    run(0, 0, 3, "cw_k2", 1'b1);
    run(0, 0, 4, "cw_c3_unchanged", 1'b1);

    coef_we = 1'b1; coef_addr = '0; coef_data = 8'sd7;
    in_valid = 1'b1; in_ch = '0; in_data = 8'sd2;
    #1;
    check("cw_in_ready_low", int'(in_ready), 0);
    step();
    coef_we = 1'b0;
    #1;
    check("cw_in_ready_next", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("cw_accepted", int'(busy), 1);
    wait_out(lat);
    check("cw_new_c0_data", int'(out_data), exp_f(19));
    release_out();

    // Reset in the middle of MAC.
    accept(0, 1);
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy",      int'(busy),      0);
    step();
    rst = 1'b0;
    #1;
    run(0, 1, 0, "post_rst_imp", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
